alu_sequencer: RTL and testbench

Multi-cycle, parametrised successor to the combinational opcode decoder. Accepts instructions over a valid/ready handshake, decodes opcode and register fields into registered ALU controls, and sequences single-cycle ops (ADD/SUB/AND/OR) and multi-cycle ops (MUL/DIV) through an explicit FSM. Sits between the instruction fetch stage and the ALU and register file, and issues the register-file write enable.

---
 rtl/alu_sequencer.sv | 272 +++++++++++++++++++++++++++
 tb/tb_alu_sequencer.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_sequencer.sv
// -----------------------------------------------------------------------------
// alu_sequencer
//
// Multi-cycle instruction sequencer that sits between instruction fetch and
// the ALU / register file. It accepts one instruction at a time over a
// valid/ready handshake and decodes it into registered ALU controls. Single-
// cycle ops (ADD/SUB/AND/OR) complete in four cycles. Multi-cycle ops
// (MUL/DIV) issue an alu_start pulse and then wait for alu_done, bounded by
// MAX_WAIT cycles.
//
// Instruction layout (MSB first): opcode[3:0] | rd | rs | rt | unused.
// INSTR_W must be at least 4 + 3*REG_AW.
//
// Optional feature macro: ILLEGAL_TRAP_EN
//   defined     : an undefined opcode pulses `illegal` in its EXEC cycle and
//                 returns to IDLE without write-back.
//   not defined : an undefined opcode decodes as ADD, and `illegal` is tied to 0.
//
// Ports
//   clk          in   rising-edge clock
//   rst_n        in   asynchronous active-low reset
//   instr_valid  in   fetch presents an instruction
//   instr        in   instruction word [INSTR_W]
//   instr_ready  out  sequencer can accept (registered; low during reset)
//   op_select    out  ALU operation select [3]
//   sub          out  ALU subtract control
//   rd_addr      out  destination register [REG_AW]
//   rs_addr      out  source register A [REG_AW]
//   rt_addr      out  source register B [REG_AW]
//   alu_start    out  one-cycle start pulse for MUL/DIV
//   alu_done     in   multi-cycle ALU result ready (sampled only in WAIT_ALU)
//   reg_we       out  register-file write enable, one-cycle pulse
//   timeout      out  sticky WAIT_ALU overrun flag, cleared only by reset
//   illegal      out  undefined-opcode pulse (trap build only)
//   retired      out  completed write-back count [CNT_W], wraps
// -----------------------------------------------------------------------------
module alu_sequencer #(
  parameter int INSTR_W  = 16,
  parameter int REG_AW   = 4,
  parameter int CNT_W    = 16,
  parameter int MAX_WAIT = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               instr_valid,
  input  logic [INSTR_W-1:0] instr,
  output logic               instr_ready,
  output logic [2:0]         op_select,
  output logic               sub,
  output logic [REG_AW-1:0]  rd_addr,
  output logic [REG_AW-1:0]  rs_addr,
  output logic [REG_AW-1:0]  rt_addr,
  output logic               alu_start,
  input  logic               alu_done,
  output logic               reg_we,
  output logic               timeout,
  output logic               illegal,
  output logic [CNT_W-1:0]   retired
);

  // Wide enough to hold MAX_WAIT-1, and never zero width when MAX_WAIT == 1.
  localparam int WAIT_W = $clog2(MAX_WAIT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DECODE,
    S_EXEC,
    S_WAIT_ALU,
    S_WB
  } state_t;

  typedef enum logic [3:0] {
    OPC_ADD = 4'b0000,
    OPC_SUB = 4'b0001,
    OPC_AND = 4'b0010,
    OPC_OR  = 4'b0011,
    OPC_MUL = 4'b0100,
    OPC_DIV = 4'b0101
  } opcode_t;

  state_t              state;
  state_t              next_state;
  logic [INSTR_W-1:0]  instr_q;
  logic                multi_q;
  logic [WAIT_W-1:0]   wait_cnt;
  logic                accept;
  logic                wait_expired;

  // Decoded view of the latched instruction.
  logic [3:0]          opcode;
  logic [2:0]          dec_op;
  logic                dec_sub;
  logic                dec_multi;
  logic                dec_illegal;

`ifdef ILLEGAL_TRAP_EN
  logic                illegal_q;
`endif

  assign opcode = instr_q[INSTR_W-1 -: 4];

  // instr_ready is only ever high in IDLE, but qualifying with the state keeps
  // the accept condition obviously correct.
  assign accept       = instr_valid && instr_ready && (state == S_IDLE);
  // The counter is cleared in EXEC and advances once per WAIT_ALU cycle, so it
  // holds MAX_WAIT-1 during WAIT_ALU cycle number MAX_WAIT.
  assign wait_expired = (wait_cnt == WAIT_W'(MAX_WAIT - 1));

  // ---------------------------------------------------------------------------
  // Opcode decode
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable written in a combinational block gets a default
    // first; a path that leaves one unassigned infers a latch.
    dec_op      = 3'b000;
    dec_sub     = 1'b0;
    dec_multi   = 1'b0;
    dec_illegal = 1'b0;
    case (opcode)
      OPC_ADD: dec_op = 3'b000;
      OPC_SUB: begin
        dec_op  = 3'b001;
        dec_sub = 1'b1;
      end
      OPC_AND: dec_op = 3'b010;
      OPC_OR:  dec_op = 3'b011;
      OPC_MUL: begin
        dec_op    = 3'b100;
        dec_multi = 1'b1;
      end
      OPC_DIV: begin
        dec_op    = 3'b101;
        dec_multi = 1'b1;
      end
      // Undefined opcodes keep the ADD defaults; the trap build also flags them.
      default: dec_illegal = 1'b1;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state and Moore-style pulse outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    next_state = state;
    alu_start  = 1'b0;
    reg_we     = 1'b0;
    case (state)
      S_IDLE: begin
        if (accept) next_state = S_DECODE;
      end
      S_DECODE: begin
        next_state = S_EXEC;
      end
      S_EXEC: begin
`ifdef ILLEGAL_TRAP_EN
        if (illegal_q) begin
          next_state = S_IDLE;
        end else
`endif
        if (multi_q) begin
          alu_start  = 1'b1;
          next_state = S_WAIT_ALU;
        end else begin
          next_state = S_WB;
        end
      end
      S_WAIT_ALU: begin
        // A result arriving in the last permitted cycle still wins over timeout.
        if (alu_done) begin
          next_state = S_WB;
        end else if (wait_expired) begin
          next_state = S_IDLE;
        end
      end
      S_WB: begin
        reg_we     = 1'b1;
        next_state = S_IDLE;
      end
      default: next_state = S_IDLE;
    endcase
  end

`ifdef ILLEGAL_TRAP_EN
  assign illegal = (state == S_EXEC) && illegal_q;
`else
  assign illegal = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Instruction latch and registered ALU controls
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_q   <= '0;
      multi_q   <= 1'b0;
      op_select <= 3'b000;
      sub       <= 1'b0;
      rd_addr   <= '0;
      rs_addr   <= '0;
      rt_addr   <= '0;
`ifdef ILLEGAL_TRAP_EN
      illegal_q <= 1'b0;
`endif
    end else begin
      if (accept) begin
        instr_q <= instr;
      end
      // Controls change only on DECODE exit and hold until the next DECODE.
      if (state == S_DECODE) begin
        op_select <= dec_op;
        sub       <= dec_sub;
        multi_q   <= dec_multi;
        rd_addr   <= instr_q[INSTR_W-5 -: REG_AW];
        rs_addr   <= instr_q[INSTR_W-5-REG_AW -: REG_AW];
        rt_addr   <= instr_q[INSTR_W-5-2*REG_AW -: REG_AW];
`ifdef ILLEGAL_TRAP_EN
        illegal_q <= dec_illegal;
`endif
      end
    end
  end

`ifndef ILLEGAL_TRAP_EN
  // Undefined opcodes simply complete as ADD in this build.
  logic unused_dec_illegal;
  assign unused_dec_illegal = dec_illegal;
`endif

  // ---------------------------------------------------------------------------
  // Handshake, wait counter, timeout and retired counter
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_ready <= 1'b0;
      wait_cnt    <= '0;
      timeout     <= 1'b0;
      retired     <= '0;
    end else begin
      // Registered so that ready stays low through reset and rises one edge
      // after release, and is high exactly in IDLE cycles thereafter.
      instr_ready <= (next_state == S_IDLE);

      if (state == S_EXEC) begin
        wait_cnt <= '0;
      end else if (state == S_WAIT_ALU) begin
        wait_cnt <= wait_cnt + WAIT_W'(1);
      end

      if ((state == S_WAIT_ALU) && !alu_done && wait_expired) begin
        timeout <= 1'b1;
      end

      if (state == S_WB) begin
        retired <= retired + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// -----------------------------------------------------------------------------
// tb_alu_sequencer
//
// Directed testbench for alu_sequencer (CNT_W=4 so counter wrap is reachable,
// MAX_WAIT=32). Inputs are driven and outputs sampled on the falling edge.
// Cycle naming below: the instruction is accepted at rising edge N, and
// "cycle N+k" is the cycle that ends at rising edge N+k.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_alu_sequencer;

  localparam int INSTR_W  = 16;
  localparam int REG_AW   = 4;
  localparam int CNT_W    = 4;
  localparam int MAX_WAIT = 32;

  logic               clk;
  logic               rst_n;
  logic               instr_valid;
  logic [INSTR_W-1:0] instr;
  logic               instr_ready;
  logic [2:0]         op_select;
  logic               sub;
  logic [REG_AW-1:0]  rd_addr;
  logic [REG_AW-1:0]  rs_addr;
  logic [REG_AW-1:0]  rt_addr;
  logic               alu_start;
  logic               alu_done;
  logic               reg_we;
  logic               timeout;
  logic               illegal;
  logic [CNT_W-1:0]   retired;

  int checks = 0;
  int errors = 0;
  logic [CNT_W-1:0] exp_ret = '0;

  alu_sequencer #(
    .INSTR_W (INSTR_W),
    .REG_AW  (REG_AW),
    .CNT_W   (CNT_W),
    .MAX_WAIT(MAX_WAIT)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .instr_valid(instr_valid),
    .instr      (instr),
    .instr_ready(instr_ready),
    .op_select  (op_select),
    .sub        (sub),
    .rd_addr    (rd_addr),
    .rs_addr    (rs_addr),
    .rt_addr    (rt_addr),
    .alu_start  (alu_start),
    .alu_done   (alu_done),
    .reg_we     (reg_we),
    .timeout    (timeout),
    .illegal    (illegal),
    .retired    (retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Presents a word and waits (bounded) for it to be accepted. Returns at the
  // falling edge of cycle N+1 with instr_valid dropped.
  task automatic issue(input logic [INSTR_W-1:0] word);
    bit ok;
    ok          = 1'b0;
    instr       = word;
    instr_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      if (instr_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL accept_wait: instr_ready never rose for %h", word);
    end
    @(negedge clk);
    instr_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; instr_valid = 1'b0; instr = '0; alu_done = 1'b0;
    step(3);
    checks++;
    if ({instr_ready, op_select, sub, rd_addr, rs_addr, rt_addr, alu_start,
         reg_we, timeout, illegal, retired} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: some output nonzero during reset (ready=%b retired=%0d)",
               instr_ready, retired);
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if (instr_ready !== 1'b0) begin
      errors++; $display("FAIL ready_at_release: got %b want 0", instr_ready);
    end
    step(1);
    checks++;
    if (instr_ready !== 1'b1) begin
      errors++; $display("FAIL ready_after_release: got %b want 1", instr_ready);
    end
    // Abort a MUL in the middle of WAIT_ALU.
    issue(16'h4123);
    step(4);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({instr_ready, op_select, sub, rd_addr, rs_addr, rt_addr, alu_start,
         reg_we, timeout, illegal, retired} !== '0) begin
      errors++;
      $display("FAIL reset_mid_wait: outputs not cleared (op=%b ready=%b)",
               op_select, instr_ready);
    end
    step(2);
    rst_n = 1'b1;
    #1;
    checks++;
    if (instr_ready !== 1'b0) begin
      errors++; $display("FAIL ready_at_release2: got %b want 0", instr_ready);
    end
    step(1);
    checks++;
    if ({instr_ready, reg_we, retired} !== {1'b1, 1'b0, 4'd0}) begin
      errors++;
      $display("FAIL post_abort: ready=%b reg_we=%b retired=%0d want 1/0/0",
               instr_ready, reg_we, retired);
    end
    exp_ret = '0;
  endtask

  task automatic test_sub();
    issue(16'h1234);
    checks++;
    if ({reg_we, alu_start} !== 2'b00) begin
      errors++; $display("FAIL sub_decode_cycle: reg_we=%b alu_start=%b want 0/0", reg_we, alu_start);
    end
    step(1);
    checks++;
    if ({op_select, sub, rd_addr, rs_addr, rt_addr, alu_start} !==
        {3'b001, 1'b1, 4'd2, 4'd3, 4'd4, 1'b0}) begin
      errors++;
      $display("FAIL sub_fields: op=%b sub=%b rd=%0d rs=%0d rt=%0d start=%b want 001/1/2/3/4/0",
               op_select, sub, rd_addr, rs_addr, rt_addr, alu_start);
    end
    step(1);
    checks++;
    if ({reg_we, retired} !== {1'b1, exp_ret}) begin
      errors++; $display("FAIL sub_wb: reg_we=%b retired=%0d want 1/%0d", reg_we, retired, exp_ret);
    end
    step(1);
    exp_ret = exp_ret + 1'b1;
    checks++;
    if ({reg_we, instr_ready, retired} !== {1'b0, 1'b1, exp_ret}) begin
      errors++;
      $display("FAIL sub_done: reg_we=%b ready=%b retired=%0d want 0/1/%0d",
               reg_we, instr_ready, retired, exp_ret);
    end
  endtask

  task automatic test_mul();
    issue(16'h4123);
    step(1);
    checks++;
    if ({alu_start, op_select, rd_addr, rs_addr, rt_addr} !==
        {1'b1, 3'b100, 4'd1, 4'd2, 4'd3}) begin
      errors++;
      $display("FAIL mul_start: start=%b op=%b rd=%0d rs=%0d rt=%0d want 1/100/1/2/3",
               alu_start, op_select, rd_addr, rs_addr, rt_addr);
    end
    alu_done = 1'b1;                 // same cycle as alu_start: must be ignored
    step(1);
    alu_done = 1'b0;
    for (int c = 3; c <= 7; c++) begin
      checks++;
      if ({reg_we, alu_start, op_select} !== {1'b0, 1'b0, 3'b100}) begin
        errors++;
        $display("FAIL mul_wait_N+%0d: reg_we=%b start=%b op=%b want 0/0/100",
                 c, reg_we, alu_start, op_select);
      end
      if (c == 7) alu_done = 1'b1;   // first seen in N+7 (k=5)
      step(1);
    end
    checks++;
    if ({reg_we, op_select} !== {1'b1, 3'b100}) begin
      errors++; $display("FAIL mul_wb_N+8: reg_we=%b op=%b want 1/100", reg_we, op_select);
    end
    alu_done = 1'b0;
    step(1);
    exp_ret = exp_ret + 1'b1;
    checks++;
    if ({reg_we, instr_ready, retired} !== {1'b0, 1'b1, exp_ret}) begin
      errors++;
      $display("FAIL mul_done: reg_we=%b ready=%b retired=%0d want 0/1/%0d",
               reg_we, instr_ready, retired, exp_ret);
    end
  endtask

  task automatic test_timeout();
    issue(16'h5456);
    step(1);
    checks++;
    if ({alu_start, op_select} !== {1'b1, 3'b101}) begin
      errors++; $display("FAIL div_start: start=%b op=%b want 1/101", alu_start, op_select);
    end
    for (int c = 3; c <= 34; c++) begin
      step(1);
      checks++;
      if ({reg_we, timeout, instr_ready} !== 3'b000) begin
        errors++;
        $display("FAIL div_wait_N+%0d: reg_we=%b timeout=%b ready=%b want 0/0/0",
                 c, reg_we, timeout, instr_ready);
      end
    end
    step(1);
    checks++;
    if ({timeout, instr_ready, reg_we, retired} !== {1'b1, 1'b1, 1'b0, exp_ret}) begin
      errors++;
      $display("FAIL div_timeout: timeout=%b ready=%b reg_we=%b retired=%0d want 1/1/0/%0d",
               timeout, instr_ready, reg_we, retired, exp_ret);
    end
  endtask

  task automatic test_illegal();
    issue(16'hF000);
    step(1);
`ifdef ILLEGAL_TRAP_EN
    checks++;
    if ({illegal, reg_we} !== 2'b10) begin
      errors++; $display("FAIL illegal_pulse: illegal=%b reg_we=%b want 1/0", illegal, reg_we);
    end
    step(1);
    checks++;
    if ({illegal, reg_we, instr_ready, retired} !== {1'b0, 1'b0, 1'b1, exp_ret}) begin
      errors++;
      $display("FAIL illegal_return: illegal=%b reg_we=%b ready=%b retired=%0d want 0/0/1/%0d",
               illegal, reg_we, instr_ready, retired, exp_ret);
    end
`else
    checks++;
    if ({illegal, op_select, sub} !== {1'b0, 3'b000, 1'b0}) begin
      errors++;
      $display("FAIL undef_as_add: illegal=%b op=%b sub=%b want 0/000/0", illegal, op_select, sub);
    end
    step(1);
    checks++;
    if ({reg_we, illegal} !== 2'b10) begin
      errors++; $display("FAIL undef_wb: reg_we=%b illegal=%b want 1/0", reg_we, illegal);
    end
    step(1);
    exp_ret = exp_ret + 1'b1;
    checks++;
    if (retired !== exp_ret) begin
      errors++; $display("FAIL undef_retired: got %0d want %0d", retired, exp_ret);
    end
`endif
    checks++;
    if (timeout !== 1'b1) begin
      errors++; $display("FAIL timeout_sticky: got %b want 1", timeout);
    end
  endtask

  task automatic test_wrap();
    rst_n = 1'b0;
    step(2);
    rst_n = 1'b1;
    step(1);
    checks++;
    if ({timeout, retired} !== {1'b0, 4'd0}) begin
      errors++; $display("FAIL wrap_reset: timeout=%b retired=%0d want 0/0", timeout, retired);
    end
    for (int i = 0; i < 17; i++) begin
      issue(16'h0123);
      step(3);
    end
    checks++;
    if (retired !== 4'd1) begin
      errors++; $display("FAIL retired_wrap: got %0d want 1", retired);
    end
    exp_ret = 4'd1;
  endtask

  task automatic test_back_to_back();
    logic [19:0] acc_mask;
    logic [19:0] we_mask;
    bit ok;
    acc_mask = '0; we_mask = '0; ok = 1'b0;
    instr = 16'h0ABC; instr_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (instr_ready) begin ok = 1'b1; break; end
      step(1);
    end
    checks++;
    if (!ok) begin
      errors++; $display("FAIL b2b_start: instr_ready never rose");
    end
    for (int i = 0; i < 20; i++) begin
      acc_mask[i] = instr_ready && instr_valid;
      we_mask[i]  = reg_we;
      step(1);
    end
    instr_valid = 1'b0;
    checks++;
    if (acc_mask !== 20'h11111) begin
      errors++; $display("FAIL b2b_accepts: mask=%h want 11111", acc_mask);
    end
    checks++;
    if (we_mask !== 20'h88888) begin
      errors++; $display("FAIL b2b_reg_we: mask=%h want 88888", we_mask);
    end
    step(1);
    exp_ret = exp_ret + 4'd5;
    checks++;
    if (retired !== exp_ret) begin
      errors++; $display("FAIL b2b_retired: got %0d want %0d", retired, exp_ret);
    end
  endtask

  initial begin
    test_reset();
    test_sub();
    test_mul();
    test_timeout();
    test_illegal();
    test_wrap();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
